// File: rtl/spi_request_arbiter_pkg.sv
// Shared constants and state encoding for the quick_spi request arbiter and its clients.
// The sensor configurator and gain updater import the same widths.
package spi_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_SLAVE_WIDTH = 2;
    localparam int RD_WIDTH        = 8;

    // Watchdog counter width; a disabled watchdog still needs a 1-bit register.
    function automatic int cnt_width(input int timeout_cycles);
        return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/spi_request_arbiter_if.sv
// Client-request and quick_spi master signals shared between the arbiter and its surroundings.
// The slave modport is the arbiter side; the master modport drives requests and the SPI master's replies.
interface spi_request_arbiter_if
    import spi_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTERS = 2,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int SLAVE_WIDTH    = DEF_SLAVE_WIDTH
);
    logic [NUM_REQUESTERS-1:0]             req;
    logic [NUM_REQUESTERS*DATA_WIDTH-1:0]  req_data;
    logic [NUM_REQUESTERS*SLAVE_WIDTH-1:0] req_slave;
    logic [NUM_REQUESTERS-1:0]             req_operation;
    logic [NUM_REQUESTERS-1:0]             grant;
    logic [NUM_REQUESTERS-1:0]             done;
    logic [RD_WIDTH-1:0]                   rd_data;
    logic                                  timeout_error;
    logic                                  spi_enable;
    logic                                  spi_start_transaction;
    logic [DATA_WIDTH-1:0]                 spi_outgoing_data;
    logic [SLAVE_WIDTH-1:0]                spi_slave;
    logic                                  spi_operation;
    logic                                  spi_end_of_transaction;
    logic [RD_WIDTH-1:0]                   spi_incoming_data;

    modport slave (
        input  req, req_data, req_slave, req_operation,
        input  spi_end_of_transaction, spi_incoming_data,
        output grant, done, rd_data, timeout_error,
        output spi_enable, spi_start_transaction, spi_outgoing_data, spi_slave, spi_operation
    );

    modport master (
        output req, req_data, req_slave, req_operation,
        output spi_end_of_transaction, spi_incoming_data,
        input  grant, done, rd_data, timeout_error,
        input  spi_enable, spi_start_transaction, spi_outgoing_data, spi_slave, spi_operation
    );

endinterface

// File: rtl/spi_request_arbiter_rr.sv
// Combinational round-robin picker: searches upward from last_i + 1 with wrap and
// returns the first active request as a one-hot vector plus its index.
module rr_priority_select #(
    parameter int NUM_REQUESTERS = 2
) (
    input  logic [NUM_REQUESTERS-1:0]         req_i,
    input  logic [$clog2(NUM_REQUESTERS)-1:0] last_i,
    output logic [NUM_REQUESTERS-1:0]         winner_o,
    output logic [$clog2(NUM_REQUESTERS)-1:0] winner_idx_o,
    output logic                              valid_o
);

    localparam int IW = $clog2(NUM_REQUESTERS);

    int idx;

    always_comb begin
        winner_o     = '0;
        winner_idx_o = '0;
        valid_o      = 1'b0;
        idx          = 0;
        for (int k = 1; k <= NUM_REQUESTERS; k++) begin
            idx = (int'(last_i) + k) % NUM_REQUESTERS;
            if (!valid_o && req_i[idx]) begin
                valid_o       = 1'b1;
                winner_o[idx] = 1'b1;
                winner_idx_o  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/spi_request_arbiter.sv
// Grants the single quick_spi master to one register-access client at a time,
// round-robin, with a BUSY watchdog that forces an error completion on a hung transfer.
//
// state | meaning
// IDLE  | master free; pick a winner from req and latch its command fields
// BUSY  | transaction owned by the winner; spi_* and grant held, watchdog counting
// GAP   | one dead cycle after completion so the master settles; req ignored
module spi_request_arbiter
    import spi_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTERS = 2,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int SLAVE_WIDTH    = DEF_SLAVE_WIDTH,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  reset_n,
    spi_request_arbiter_if.slave  bus
);

    localparam int IW = $clog2(NUM_REQUESTERS);
    localparam int CW = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TO_VAL   = CW'(TIMEOUT_CYCLES);
    localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQUESTERS - 1);

    arb_state_t                state_q, state_d;
    logic [NUM_REQUESTERS-1:0] grant_q, grant_d;
    logic [NUM_REQUESTERS-1:0] done_q, done_d;
    logic [RD_WIDTH-1:0]       rd_q, rd_d;
    logic                      terr_q, terr_d;
    logic                      en_q, en_d;
    logic                      start_q, start_d;
    logic [DATA_WIDTH-1:0]     odata_q, odata_d;
    logic [SLAVE_WIDTH-1:0]    slv_q, slv_d;
    logic                      op_q, op_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [IW-1:0]             last_q, last_d;
    logic [IW-1:0]             win_q, win_d;

    logic [NUM_REQUESTERS-1:0] pick_oh;
    logic [IW-1:0]             pick_idx;
    logic                      pick_vld;
    logic [CW-1:0]             cnt_inc;
    logic                      expire;

    rr_priority_select #(
        .NUM_REQUESTERS (NUM_REQUESTERS)
    ) u_rr (
        .req_i        (bus.req),
        .last_i       (last_q),
        .winner_o     (pick_oh),
        .winner_idx_o (pick_idx),
        .valid_o      (pick_vld)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            done_q  <= '0;
            rd_q    <= '0;
            terr_q  <= 1'b0;
            en_q    <= 1'b0;
            start_q <= 1'b0;
            odata_q <= '0;
            slv_q   <= '0;
            op_q    <= 1'b0;
            cnt_q   <= '0;
            last_q  <= LAST_RST;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            rd_q    <= rd_d;
            terr_q  <= terr_d;
            en_q    <= en_d;
            start_q <= start_d;
            odata_q <= odata_d;
            slv_q   <= slv_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            win_q   <= win_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        rd_d    = rd_q;
        terr_d  = 1'b0;
        en_d    = en_q;
        start_d = start_q;
        odata_d = odata_q;
        slv_d   = slv_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        win_d   = win_q;

        // Saturating increment; expiry means this BUSY edge is the TIMEOUT_CYCLES-th one.
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
        expire  = (TIMEOUT_CYCLES != 0) && (cnt_inc == TO_VAL);

        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_oh;
                    win_d   = pick_idx;
                    for (int i = 0; i < NUM_REQUESTERS; i++) begin
                        if (pick_oh[i]) begin
                            odata_d = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
                            slv_d   = bus.req_slave[i*SLAVE_WIDTH +: SLAVE_WIDTH];
                            op_d    = bus.req_operation[i];
                        end
                    end
                    en_d    = 1'b1;
                    start_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_inc;
                // A real end-of-transaction on the expiry edge takes precedence over the watchdog.
                if (bus.spi_end_of_transaction || expire) begin
                    done_d  = grant_q;
                    rd_d    = bus.spi_end_of_transaction ? bus.spi_incoming_data : '0;
                    terr_d  = !bus.spi_end_of_transaction;
                    grant_d = '0;
                    en_d    = 1'b0;
                    start_d = 1'b0;
                    last_d  = win_q;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.grant                 = grant_q;
    assign bus.done                  = done_q;
    assign bus.rd_data               = rd_q;
    assign bus.timeout_error         = terr_q;
    assign bus.spi_enable            = en_q;
    assign bus.spi_start_transaction = start_q;
    assign bus.spi_outgoing_data     = odata_q;
    assign bus.spi_slave             = slv_q;
    assign bus.spi_operation         = op_q;

endmodule
